// File: rtl/c_ext_fetch_sequencer.sv
// IF-stage C-extension fetch sequencer: tracks parcel position, the buffered word,
// sequences word-straddling 32-bit instructions and decides the PC advance.
module c_ext_fetch_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc_reg,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_effective_instr,
    input  logic            i_is_compressed,
    output logic            o_prev_was_compressed_at_lo,
    output logic            o_prev_was_compressed_at_lo_saved,
    output logic            o_stall_registered,
    output logic [XLEN-1:0] o_instr_buffer,
    output logic            o_spanning_wait_for_fetch,
    output logic            o_spanning_in_progress,
    output logic [15:0]     o_spanning_buffer,
    output logic [15:0]     o_spanning_second_half,
    output logic            o_fetch_next_word,
    output logic [2:0]      o_pc_advance
);

    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        SPAN_WAIT  = 2'd1,
        SPAN_READY = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   blocked;
    logic   pc_hi;
    logic   unused_pc_bits;

    assign pc_hi          = i_pc_reg[1];
    assign blocked        = i_stall | i_flush | ~i_rst_n;
    assign unused_pc_bits = ^{i_pc_reg[XLEN-1:2], i_pc_reg[0]};

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the two combinational outputs (advance / next-word request)
    always_comb begin
        state_next        = state;
        o_pc_advance      = 3'd0;
        o_fetch_next_word = 1'b0;
        if (i_flush) begin
            state_next = RUN;
        end else if (!blocked) begin
            unique case (state)
                RUN: begin
                    if (i_is_compressed) begin
                        o_pc_advance = 3'd2;
                    end else if (!pc_hi) begin
                        o_pc_advance = 3'd4;
                    end else begin
                        o_fetch_next_word = 1'b1;
                        state_next        = SPAN_WAIT;
                    end
                end
                SPAN_WAIT: begin
                    o_fetch_next_word = 1'b1;
                    state_next        = SPAN_READY;
                end
                SPAN_READY: begin
                    o_pc_advance = 3'd4;
                    state_next   = RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // Fetch-state registers; stall holds everything but the stall tracker
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_prev_was_compressed_at_lo       <= 1'b0;
            o_prev_was_compressed_at_lo_saved <= 1'b0;
            o_stall_registered                <= 1'b0;
            o_instr_buffer                    <= '0;
            o_spanning_wait_for_fetch         <= 1'b0;
            o_spanning_in_progress            <= 1'b0;
            o_spanning_buffer                 <= '0;
            o_spanning_second_half            <= '0;
        end else begin
            o_stall_registered        <= i_stall;
            o_spanning_wait_for_fetch <= (state_next == SPAN_WAIT);
            o_spanning_in_progress    <= (state_next == SPAN_READY);
            if (i_flush) begin
                o_prev_was_compressed_at_lo       <= 1'b0;
                o_prev_was_compressed_at_lo_saved <= 1'b0;
                o_instr_buffer                    <= '0;
                o_spanning_buffer                 <= '0;
                o_spanning_second_half            <= '0;
            end else if (i_stall) begin
                if (!o_stall_registered) begin
                    o_prev_was_compressed_at_lo_saved <= o_prev_was_compressed_at_lo;
                end
            end else begin
                unique case (state)
                    RUN: begin
                        if (i_is_compressed && !pc_hi) begin
                            o_prev_was_compressed_at_lo <= 1'b1;
                            o_instr_buffer              <= i_effective_instr;
                        end else begin
                            o_prev_was_compressed_at_lo <= 1'b0;
                        end
                        if (!i_is_compressed && pc_hi) begin
                            o_spanning_buffer <= i_effective_instr[XLEN-1:XLEN-HALF_W];
                        end
                    end
                    SPAN_WAIT: begin
                        o_spanning_second_half <= i_instr[HALF_W-1:0];
                        o_instr_buffer         <= i_instr;
                    end
                    SPAN_READY: begin
                        // Upper half of the fetched word is the next parcel at PC[1]=1
                        o_prev_was_compressed_at_lo <= 1'b1;
                    end
                    default: begin
                        o_prev_was_compressed_at_lo <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_c_ext_fetch_sequencer.sv
// Self-checking bench for c_ext_fetch_sequencer: directed scenarios plus a
// randomized run against a behavioural model of the fetch rules.
module tb_c_ext_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] pc_reg;
    logic [31:0] instr;
    logic [31:0] eff;
    logic        comp;
    logic        prev_lo;
    logic        prev_lo_saved;
    logic        stall_reg;
    logic [31:0] ibuf;
    logic        span_wait;
    logic        span_ready;
    logic [15:0] span_buf;
    logic [15:0] span_hi;
    logic        fetch_next;
    logic [2:0]  pc_adv;

    int n_cmp = 0;
    int n_err = 0;

    c_ext_fetch_sequencer #(.XLEN(32)) dut (
        .i_clk                             (clk),
        .i_rst_n                           (rst_n),
        .i_stall                           (stall),
        .i_flush                           (flush),
        .i_pc_reg                          (pc_reg),
        .i_instr                           (instr),
        .i_effective_instr                 (eff),
        .i_is_compressed                   (comp),
        .o_prev_was_compressed_at_lo       (prev_lo),
        .o_prev_was_compressed_at_lo_saved (prev_lo_saved),
        .o_stall_registered                (stall_reg),
        .o_instr_buffer                    (ibuf),
        .o_spanning_wait_for_fetch         (span_wait),
        .o_spanning_in_progress            (span_ready),
        .o_spanning_buffer                 (span_buf),
        .o_spanning_second_half            (span_hi),
        .o_fetch_next_word                 (fetch_next),
        .o_pc_advance                      (pc_adv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: span_phase counts cycles into a straddling instruction
    int          m_phase;
    logic        m_prev, m_saved, m_sreg;
    logic [31:0] m_buf;
    logic [15:0] m_sb, m_sh;

    function automatic logic [2:0] m_adv();
        if (!rst_n || stall || flush) return 3'd0;
        if (m_phase == 1) return 3'd0;
        if (m_phase == 2) return 3'd4;
        if (comp) return 3'd2;
        return pc_reg[1] ? 3'd0 : 3'd4;
    endfunction

    function automatic logic m_fetch();
        if (!rst_n || stall || flush) return 1'b0;
        return (m_phase == 1) || (m_phase == 0 && pc_reg[1] && !comp);
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_phase = 0; m_prev = 0; m_saved = 0; m_sreg = 0; m_buf = 0; m_sb = 0; m_sh = 0;
        end else begin
            if (flush) begin
                m_phase = 0; m_prev = 0; m_saved = 0; m_buf = 0; m_sb = 0; m_sh = 0;
            end else if (stall) begin
                if (!m_sreg) m_saved = m_prev;
            end else if (m_phase == 1) begin
                m_sh = instr[15:0]; m_buf = instr; m_phase = 2;
            end else if (m_phase == 2) begin
                m_prev = 1'b1; m_phase = 0;
            end else begin
                m_prev = comp && !pc_reg[1];
                if (comp && !pc_reg[1]) m_buf = eff;
                if (!comp && pc_reg[1]) begin
                    m_sb = eff[31:16]; m_phase = 1;
                end
            end
            m_sreg = stall;
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] pc,
                         input logic [31:0] mem, input logic [31:0] e, input logic c);
        rst_n = r; stall = s; flush = f; pc_reg = pc; instr = mem; eff = e; comp = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        tick();
        drive(1, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    endtask

    // Enter SPAN_WAIT with low half 0x0093 buffered
    task automatic enter_span_wait();
        do_reset();
        drive(1, 0, 0, 32'h2, 32'h0093_4501, 32'h0093_4501, 0);
        tick();
    endtask

    task automatic test_reset();
        drive(0, 1, 1, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
        tick();
        n_cmp++;
        if ({prev_lo, prev_lo_saved, stall_reg, ibuf, span_wait, span_ready, span_buf, span_hi, fetch_next, pc_adv} !== 72'd0) begin
            n_err++;
            $display("FAIL reset_all_zero got buf=%h sb=%h sh=%h adv=%0d fetch=%b flags=%b%b%b%b%b want all 0",
                     ibuf, span_buf, span_hi, pc_adv, fetch_next, prev_lo, prev_lo_saved, stall_reg, span_wait, span_ready);
        end
    endtask

    task automatic test_compressed();
        do_reset();
        drive(1, 0, 0, 32'h0, 32'h0001_4501, 32'h0001_4501, 1);
        n_cmp++; if (pc_adv !== 3'd2) begin n_err++; $display("FAIL c_lo_adv got %0d want 2", pc_adv); end
        tick();
        n_cmp++; if ({prev_lo, ibuf} !== {1'b1, 32'h0001_4501}) begin n_err++; $display("FAIL c_lo_state got prev=%b buf=%h want 1 00014501", prev_lo, ibuf); end
        drive(1, 0, 0, 32'h2, 32'h0001_4501, 32'h0001_4501, 1);
        n_cmp++; if ({pc_adv, fetch_next} !== {3'd2, 1'b0}) begin n_err++; $display("FAIL c_hi_adv got %0d/%b want 2/0", pc_adv, fetch_next); end
        tick();
        n_cmp++; if ({prev_lo, ibuf} !== {1'b0, 32'h0001_4501}) begin n_err++; $display("FAIL c_hi_state got prev=%b buf=%h want 0 00014501", prev_lo, ibuf); end
        drive(1, 0, 0, 32'h4, 32'h0000_0013, 32'h0000_0013, 0);
        n_cmp++; if ({pc_adv, fetch_next} !== {3'd4, 1'b0}) begin n_err++; $display("FAIL full_lo_adv got %0d/%b want 4/0", pc_adv, fetch_next); end
    endtask

    task automatic test_spanning();
        do_reset();
        drive(1, 0, 0, 32'h2, 32'h0093_4501, 32'h0093_4501, 0);
        n_cmp++; if ({pc_adv, fetch_next} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL span_run_adv got %0d/%b want 0/1", pc_adv, fetch_next); end
        tick();
        n_cmp++; if ({span_wait, span_ready, span_buf} !== {2'b10, 16'h0093}) begin n_err++; $display("FAIL span_wait_state got %b%b sb=%h want 10 0093", span_wait, span_ready, span_buf); end
        drive(1, 0, 0, 32'h2, 32'h1234_0000, 32'h0093_4501, 0);
        n_cmp++; if ({pc_adv, fetch_next} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL span_wait_adv got %0d/%b want 0/1", pc_adv, fetch_next); end
        tick();
        n_cmp++; if ({span_wait, span_ready, span_hi, span_buf, ibuf} !== {2'b01, 32'h0000_0093, 32'h1234_0000}) begin
            n_err++; $display("FAIL span_ready_state got %b%b word=%h%h buf=%h want 01 00000093 12340000", span_wait, span_ready, span_hi, span_buf, ibuf); end
        n_cmp++; if ({pc_adv, fetch_next} !== {3'd4, 1'b0}) begin n_err++; $display("FAIL span_ready_adv got %0d/%b want 4/0", pc_adv, fetch_next); end
        tick();
        n_cmp++; if ({prev_lo, span_wait, span_ready} !== 3'b100) begin n_err++; $display("FAIL span_done got prev=%b flags=%b%b want 1 00", prev_lo, span_wait, span_ready); end
    endtask

    task automatic test_stall_span();
        enter_span_wait();
        drive(1, 1, 0, 32'h2, 32'hABCD_5678, 32'h0093_4501, 0);
        n_cmp++; if ({pc_adv, fetch_next, stall_reg} !== {3'd0, 1'b0, 1'b0}) begin n_err++; $display("FAIL stall_comb got %0d/%b sreg=%b want 0/0 0", pc_adv, fetch_next, stall_reg); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({span_wait, span_ready, span_hi, ibuf, stall_reg, pc_adv} !== {2'b10, 16'h0, 32'h0, 1'b1, 3'd0}) begin
                n_err++; $display("FAIL stall_hold[%0d] got %b%b sh=%h buf=%h sreg=%b adv=%0d want 10 0000 0 1 0", i, span_wait, span_ready, span_hi, ibuf, stall_reg, pc_adv); end
        end
        drive(1, 0, 0, 32'h2, 32'hABCD_5678, 32'h0093_4501, 0);
        tick();
        n_cmp++; if ({span_ready, span_hi, ibuf, stall_reg} !== {1'b1, 16'h5678, 32'hABCD_5678, 1'b0}) begin
            n_err++; $display("FAIL stall_capture got rdy=%b sh=%h buf=%h sreg=%b want 1 5678 abcd5678 0", span_ready, span_hi, ibuf, stall_reg); end
    endtask

    task automatic test_stall_saved();
        do_reset();
        drive(1, 0, 0, 32'h0, 32'h0001_4501, 32'h0001_4501, 1);
        tick();
        drive(1, 1, 0, 32'h2, 32'h0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({prev_lo, prev_lo_saved, stall_reg} !== 3'b111) begin n_err++; $display("FAIL saved[%0d] got %b%b%b want 111", i, prev_lo, prev_lo_saved, stall_reg); end
        end
        drive(1, 0, 0, 32'h2, 32'h0, 32'h0, 1);
        tick();
        n_cmp++; if ({prev_lo, prev_lo_saved, stall_reg} !== 3'b010) begin n_err++; $display("FAIL saved_release got %b%b%b want 010", prev_lo, prev_lo_saved, stall_reg); end
    endtask

    task automatic test_flush();
        enter_span_wait();
        drive(1, 0, 0, 32'h2, 32'h1234_0000, 32'h0093_4501, 0);
        tick();
        drive(1, 1, 1, 32'h2, 32'h1234_0000, 32'h0093_4501, 0);
        n_cmp++; if ({pc_adv, fetch_next} !== 4'd0) begin n_err++; $display("FAIL flush_adv got %0d/%b want 0/0", pc_adv, fetch_next); end
        tick();
        n_cmp++; if ({span_wait, span_ready, span_buf, span_hi, prev_lo, prev_lo_saved, ibuf, stall_reg} !== {68'd0, 1'b1}) begin
            n_err++; $display("FAIL flush_state got %b%b sb=%h sh=%h prev=%b%b buf=%h sreg=%b want all 0, sreg 1", span_wait, span_ready, span_buf, span_hi, prev_lo, prev_lo_saved, ibuf, stall_reg); end
    endtask

    task automatic test_reset_mid_span();
        enter_span_wait();
        drive(0, 0, 0, 32'h2, 32'h1234_0000, 32'h0093_4501, 0);
        n_cmp++; if ({pc_adv, fetch_next} !== 4'd0) begin n_err++; $display("FAIL rst_comb got %0d/%b want 0/0", pc_adv, fetch_next); end
        tick();
        drive(1, 0, 0, 32'h0, 32'h0, 32'h0, 1);
        n_cmp++;
        if ({prev_lo, prev_lo_saved, stall_reg, ibuf, span_wait, span_ready, span_buf, span_hi} !== 68'd0) begin
            n_err++; $display("FAIL rst_mid_span got %b%b%b buf=%h %b%b sb=%h sh=%h want all 0", prev_lo, prev_lo_saved, stall_reg, ibuf, span_wait, span_ready, span_buf, span_hi); end
    endtask

    task automatic test_random();
        do_reset();
        model_edge();
        m_phase = 0; m_prev = 0; m_saved = 0; m_sreg = 0; m_buf = 0; m_sb = 0; m_sh = 0;
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 40) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 15) == 0),
                  {$urandom(), 1'b0} , $urandom(), $urandom(), $urandom_range(0, 1) == 1);
            n_cmp++;
            if ({pc_adv, fetch_next} !== {m_adv(), m_fetch()}) begin
                n_err++; $display("FAIL rnd_comb[%0d] got %0d/%b want %0d/%b", i, pc_adv, fetch_next, m_adv(), m_fetch()); end
            model_edge();
            tick();
            n_cmp++;
            if ({prev_lo, prev_lo_saved, stall_reg, ibuf, span_wait, span_ready, span_buf, span_hi} !==
                {m_prev, m_saved, m_sreg, m_buf, m_phase == 1, m_phase == 2, m_sb, m_sh}) begin
                n_err++; $display("FAIL rnd_state[%0d] got %b%b%b buf=%h %b%b sb=%h sh=%h want %b%b%b buf=%h %b%b sb=%h sh=%h", i,
                    prev_lo, prev_lo_saved, stall_reg, ibuf, span_wait, span_ready, span_buf, span_hi,
                    m_prev, m_saved, m_sreg, m_buf, m_phase == 1, m_phase == 2, m_sb, m_sh); end
        end
    endtask

    initial begin
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        test_reset();
        test_compressed();
        test_spanning();
        test_stall_span();
        test_stall_saved();
        test_flush();
        test_reset_mid_span();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
